pixel_frame_loader: RTL

//  Producer side of the MLP datapath pixel/start/ready interface. Accepts a byte

---
 rtl/pixel_frame_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: packs one byte-streamed MNIST frame into a pixel vector,
// kicks the PU array with a one-cycle start, waits for done and hands the class
// result back over a valid/ready port.
// Optional watchdog on the WAIT state: define LOADER_TIMEOUT_EN.
module pixel_frame_loader #(
    parameter int NUM_PIX     = 62,
    parameter int PIX_W       = 8,
    parameter int CLASS_W     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [NUM_PIX*PIX_W-1:0] pixels,
    output logic                     start_pu,
    input  logic                     net_done,
    input  logic [CLASS_W-1:0]       mnist_class,
    output logic                     res_valid,
    output logic [CLASS_W-1:0]       res_class,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int CW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIX - 1);

    typedef enum logic [2:0] {LOAD, DRAIN, START, WAIT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          wait_first;   // first WAIT cycle: PUs are still dropping ready
    logic          len_err;
    logic          capture;
    logic          timeout_hit;
    logic          wd_expired;

`ifdef LOADER_TIMEOUT_EN
    logic [15:0] wd;
    assign wd_expired = (wd == 16'(TIMEOUT_CYC - 1));
`else
    assign wd_expired  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy = (state != LOAD) || (count != '0);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    // next-state and handshake decode
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        start_pu    = 1'b0;
        res_valid   = 1'b0;
        len_err     = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (count == LAST_IDX) begin
                        if (in_last) begin
                            state_nxt = START;
                        end else begin
                            len_err   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (in_last) begin
                        len_err = 1'b1;
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = LOAD;
            end
            START: begin
                start_pu  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!wait_first && net_done) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // frame packing, result capture and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            pixels     <= '0;
            res_class  <= '0;
            err_len    <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            err_len    <= len_err;
            wait_first <= (state == START);
            if (state == LOAD && in_valid) begin
                pixels[PIX_W*count +: PIX_W] <= in_data;
                count <= (in_last || count == LAST_IDX) ? '0 : count + 1'b1;
            end
            if (capture)          res_class <= mnist_class;
            else if (timeout_hit) res_class <= '1;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // watchdog: restarts on every WAIT entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd          <= (state == WAIT) ? wd + 16'd1 : 16'd0;
            err_timeout <= timeout_hit;
        end
    end
`endif

endmodule
